// File: rtl/powerlink_led_ctrl.sv
// Avalon-MM LED controller: per-channel static, blink, inverted blink or one-shot drive.
// Blink phase comes from a shared prescaler; one-shot pulses use per-channel down-counters.
`timescale 1ns/1ps
module powerlink_led_ctrl #(
    parameter int NUM_LED    = 2,
    parameter int CNT_W      = 24,
    parameter int DEF_PERIOD = 25000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic [NUM_LED-1:0] out_port
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_MODE   = 3'd1;
    localparam logic [2:0] A_PERIOD = 3'd2;
    localparam logic [2:0] A_PLEN   = 3'd3;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLR    = 3'd5;
    localparam logic [2:0] A_TRIG   = 3'd6;
    localparam logic [2:0] A_OUT    = 3'd7;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_TRUNC  = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] RST_PERIOD = (DEF_TRUNC == '0) ? ONE : DEF_TRUNC;

    logic [NUM_LED-1:0]   data_q, data_d;
    logic [2*NUM_LED-1:0] mode_q, mode_d;
    logic [CNT_W-1:0]     period_q, period_d;
    logic [CNT_W-1:0]     pulse_len_q, pulse_len_d;
    logic [CNT_W-1:0]     presc_q, presc_d;
    logic                 phase_q, phase_d;
    logic [CNT_W-1:0]     pulse_cnt_q [NUM_LED];
    logic [CNT_W-1:0]     pulse_cnt_d [NUM_LED];
    logic [NUM_LED-1:0]   out_q, out_d;
    logic [NUM_LED-1:0]   pulse_act;

    logic             wr_en;
    logic [CNT_W-1:0] wd_cnt;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wd_cnt    = writedata[CNT_W-1:0];
    assign unused_wd = ^writedata;
    assign out_port  = out_q;

    always_comb begin
        data_d      = data_q;
        mode_d      = mode_q;
        period_d    = period_q;
        pulse_len_d = pulse_len_q;
        if (wr_en) begin
            case (address)
                A_DATA:   data_d      = writedata[NUM_LED-1:0];
                A_MODE:   mode_d      = writedata[2*NUM_LED-1:0];
                A_PERIOD: period_d    = (wd_cnt == '0) ? ONE : wd_cnt;
                A_PLEN:   pulse_len_d = wd_cnt;
                A_SET:    data_d      = data_q | writedata[NUM_LED-1:0];
                A_CLR:    data_d      = data_q & ~writedata[NUM_LED-1:0];
                default:  ;
            endcase
        end
    end

    // A PERIOD write restarts the blink cycle so the new rate takes effect cleanly.
    always_comb begin
        presc_d = presc_q + ONE;
        phase_d = phase_q;
        if (wr_en && address == A_PERIOD) begin
            presc_d = '0;
            phase_d = 1'b0;
        end else if (presc_q >= period_q - ONE) begin
            presc_d = '0;
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LED; i++) begin
            pulse_act[i]   = (pulse_cnt_q[i] != '0);
            pulse_cnt_d[i] = pulse_cnt_q[i];
            if (wr_en && address == A_TRIG && writedata[i] &&
                mode_q[2*i +: 2] == 2'b10 && pulse_len_q != '0)
                pulse_cnt_d[i] = pulse_len_q;
            else if (wr_en && address == A_MODE && writedata[2*i +: 2] != 2'b10)
                pulse_cnt_d[i] = '0;
            else if (pulse_cnt_q[i] != '0)
                pulse_cnt_d[i] = pulse_cnt_q[i] - ONE;

            case (mode_q[2*i +: 2])
                2'b00:   out_d[i] = data_q[i];
                2'b01:   out_d[i] = data_q[i] & phase_q;
                2'b11:   out_d[i] = data_q[i] & ~phase_q;
                default: out_d[i] = pulse_act[i];
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:   readdata[NUM_LED-1:0]   = data_q;
            A_MODE:   readdata[2*NUM_LED-1:0] = mode_q;
            A_PERIOD: readdata[CNT_W-1:0]     = period_q;
            A_PLEN:   readdata[CNT_W-1:0]     = pulse_len_q;
            A_TRIG:   readdata[NUM_LED-1:0]   = pulse_act;
            A_OUT:    readdata[NUM_LED-1:0]   = out_q;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= '0;
            mode_q      <= '0;
            period_q    <= RST_PERIOD;
            pulse_len_q <= '0;
            presc_q     <= '0;
            phase_q     <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i < NUM_LED; i++) pulse_cnt_q[i] <= '0;
        end else begin
            data_q      <= data_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            pulse_len_q <= pulse_len_d;
            presc_q     <= presc_d;
            phase_q     <= phase_d;
            out_q       <= out_d;
            for (int i = 0; i < NUM_LED; i++) pulse_cnt_q[i] <= pulse_cnt_d[i];
        end
    end

endmodule

// File: tb/tb_powerlink_led_ctrl.sv
// Self-checking bench for powerlink_led_ctrl (NUM_LED=2, CNT_W=24, default reset period).
`timescale 1ns/1ps
module tb_powerlink_led_ctrl;

    localparam logic [31:0] DEF_P = 32'h007D_7840;   // 25000000 truncated to 24 bits

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [1:0]  out_port;

    powerlink_led_ctrl dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    string       name_q[$];
    logic [31:0] exp_q[$];

    task automatic push(input string n, input logic [31:0] e);
        name_q.push_back(n);
        exp_q.push_back(e);
    endtask

    task automatic obs(input logic [31:0] act);
        string n;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL scoreboard_empty: got 0x%0h with nothing expected", act);
        end else begin
            n = name_q.pop_front();
            e = exp_q.pop_front();
            if (act !== e) begin
                n_mis++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, e);
            end
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic cs);
        @(negedge clk);
        address = a; writedata = d; chipselect = cs; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        push(n, e);
        #1;
        obs(readdata);
    endtask

    // Trigger at step 0, optional retrigger at step `retrig`; sample k follows edge T+k-1.
    task automatic pulse_run(input int retrig, input int len);
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            if (e >= 1) begin
                obs(32'(out_port));
                obs(readdata);
            end
            address = 3'd6; chipselect = 1'b1; writedata = 32'h1;
            write_n = (e == 0 || e == retrig) ? 1'b0 : 1'b1;
            if (e < 29) begin
                push($sformatf("pulse_out_%0d", e + 1), (e >= 1 && e <= len) ? 32'h1 : 32'h0);
                push($sformatf("pulse_trig_rd_%0d", e + 1), (e < len) ? 32'h1 : 32'h0);
            end
        end
        write_n = 1'b1; chipselect = 1'b0;
    endtask

    typedef struct {
        logic        cs;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];
    logic [31:0] rst_exp[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 32'h3,          3'd0, 32'h3};
        vecs[1]  = '{1'b0, 3'd0, 32'h0,          3'd0, 32'h3};
        vecs[2]  = '{1'b1, 3'd5, 32'h1,          3'd0, 32'h2};
        vecs[3]  = '{1'b1, 3'd4, 32'h0,          3'd0, 32'h2};
        vecs[4]  = '{1'b1, 3'd4, 32'h1,          3'd0, 32'h3};
        vecs[5]  = '{1'b1, 3'd4, 32'hFFFF,       3'd4, 32'h0};
        vecs[6]  = '{1'b1, 3'd5, 32'h2,          3'd5, 32'h0};
        vecs[7]  = '{1'b1, 3'd7, 32'hFF,         3'd0, 32'h1};
        vecs[8]  = '{1'b1, 3'd7, 32'h0,          3'd7, 32'h1};
        vecs[9]  = '{1'b1, 3'd0, 32'hFFFF_FFFC,  3'd0, 32'h0};
        vecs[10] = '{1'b1, 3'd2, 32'h0,          3'd2, 32'h1};
        vecs[11] = '{1'b1, 3'd2, 32'hFFFF_FFFF,  3'd2, 32'h00FF_FFFF};
        vecs[12] = '{1'b1, 3'd3, 32'h1234_5678,  3'd3, 32'h0034_5678};
        vecs[13] = '{1'b1, 3'd1, 32'hFFFF_FFF3,  3'd1, 32'h3};
        vecs[14] = '{1'b1, 3'd1, 32'h0,          3'd1, 32'h0};
        vecs[15] = '{1'b1, 3'd6, 32'h3,          3'd6, 32'h0};
        rst_exp  = '{32'h0, 32'h0, DEF_P, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        // Reset state, observed while reset is held
        repeat (3) @(negedge clk);
        push("rst_out_port", 32'h0);
        obs(32'(out_port));
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            push($sformatf("rst_read_a%0d", a), rst_exp[a]);
            #1;
            obs(readdata);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Register map vectors
        for (int i = 0; i < 16; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata, vecs[i].cs);
            rd(vecs[i].raddr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // DATA=3, CLR=1, SET=0 -> out 2'b10 two edges after the CLR write
        wr(3'd1, 32'h0, 1'b1);
        wr(3'd0, 32'h3, 1'b1);
        wr(3'd5, 32'h1, 1'b1);
        wr(3'd4, 32'h0, 1'b1);
        @(negedge clk);
        push("setclr_out_port", 32'h2);
        obs(32'(out_port));
        rd(3'd0, 32'h2, "setclr_data_rd");
        rd(3'd7, 32'h2, "setclr_out_rd");

        // Blink and inverted blink with PERIOD=4
        wr(3'd1, 32'hD, 1'b1);
        wr(3'd0, 32'h3, 1'b1);
        wr(3'd2, 32'h4, 1'b1);
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            push($sformatf("blink4_k%0d", k), (((k - 1) / 4) % 2 == 0) ? 32'h2 : 32'h1);
            @(negedge clk);
            obs(32'(out_port));
        end

        // PERIOD write of 0 behaves as 1: phase toggles every cycle
        wr(3'd2, 32'h0, 1'b1);
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            push($sformatf("blink1_k%0d", k), ((k - 1) % 2 == 0) ? 32'h2 : 32'h1);
            @(negedge clk);
            obs(32'(out_port));
        end
        rd(3'd2, 32'h1, "period0_rd");

        // One-shot: 10-cycle pulse, then retrigger at cycle 7 for 17 total
        wr(3'd2, 32'd100, 1'b1);
        wr(3'd1, 32'h2, 1'b1);
        wr(3'd0, 32'h0, 1'b1);
        wr(3'd3, 32'd10, 1'b1);
        pulse_run(-1, 10);
        pulse_run(7, 17);

        // TRIG=3 with ch1 static -> only ch0; leaving mode 10 clears the pulse at once
        wr(3'd6, 32'h3, 1'b1);
        rd(3'd6, 32'h1, "trig3_only_ch0");
        wr(3'd1, 32'h0, 1'b1);
        rd(3'd6, 32'h0, "mode_exit_clears");
        wr(3'd1, 32'h2, 1'b1);
        wr(3'd3, 32'h0, 1'b1);
        wr(3'd6, 32'h1, 1'b1);
        rd(3'd6, 32'h0, "trig_plen0_ignored");

        // Reset mid-pulse (ch0) and mid-blink (ch1)
        wr(3'd1, 32'h6, 1'b1);
        wr(3'd0, 32'h3, 1'b1);
        wr(3'd2, 32'h2, 1'b1);
        wr(3'd3, 32'd20, 1'b1);
        wr(3'd6, 32'h1, 1'b1);
        repeat (5) @(negedge clk);
        push("midpulse_out0", 32'h1);
        obs(32'(out_port[0]));
        #2;
        reset_n = 1'b0;
        address = 3'd2;
        push("async_rst_out_port", 32'h0);
        push("async_rst_period", DEF_P);
        #1;
        obs(32'(out_port));
        obs(readdata);
        rd(3'd6, 32'h0, "rst_trig_rd");
        rd(3'd0, 32'h0, "rst_data_rd");
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd2, DEF_P, "post_rst_period");
        rd(3'd1, 32'h0, "post_rst_mode");
        rd(3'd3, 32'h0, "post_rst_plen");
        rd(3'd7, 32'h0, "post_rst_out");

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
